// File: rtl/vga_seq_pkg.sv
// Shared types and mode encodings for the VGA frame sequencer.
package vga_seq_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StLoad,
    StDrain,
    StHold,
    StDone
  } seq_state_e;

  localparam logic [1:0] MODE_LOOP     = 2'd0;
  localparam logic [1:0] MODE_ONESHOT  = 2'd1;
  localparam logic [1:0] MODE_PINGPONG = 2'd2;

endpackage

// File: rtl/vga_frame_sequencer_if.sv
// ROM read port and line-buffer write port driven by the frame sequencer.
interface vga_frame_sequencer_if #(
  parameter int unsigned DATA_W = 16,
  parameter int unsigned AW     = 7,
  parameter int unsigned RW     = 4
);
  logic [AW-1:0]     rom_addr;
  logic [DATA_W-1:0] rom_data;
  logic              wr_en;
  logic [RW-1:0]     wr_addr;
  logic [DATA_W-1:0] wr_data;

  modport master (
    output rom_addr,
    output wr_en,
    output wr_addr,
    output wr_data,
    input  rom_data
  );

  modport slave (
    input  rom_addr,
    input  wr_en,
    input  wr_addr,
    input  wr_data,
    output rom_data
  );
endinterface

// File: rtl/ms_hold_timer.sv
// Millisecond hold timer: counts hold_ms * TICK_CYCLES unpaused cycles after start.
module ms_hold_timer #(
  parameter int unsigned TICK_CYCLES = 25000,
  parameter int unsigned HOLD_W      = 10
) (
  input  logic              clk_vga,
  input  logic              rst_n,
  input  logic              start,
  input  logic [HOLD_W-1:0] hold_ms,
  input  logic              pause,
  output logic              expired
);

  localparam int unsigned TW = (TICK_CYCLES > 1) ? $clog2(TICK_CYCLES) : 1;
  localparam logic [TW-1:0] TickLast = TW'(TICK_CYCLES - 1);

  logic              active_q;
  logic              zero_q;
  logic [HOLD_W-1:0] ms_q;
  logic [TW-1:0]     tick_q;
  logic              counting;

  assign counting = active_q & ~pause;
  // A zero hold expires on its first unpaused cycle regardless of TICK_CYCLES.
  assign expired  = counting & (zero_q | ((tick_q == TickLast) && (ms_q == HOLD_W'(1))));

  always_ff @(posedge clk_vga or negedge rst_n) begin
    if (!rst_n) begin
      active_q <= 1'b0;
      zero_q   <= 1'b0;
      ms_q     <= '0;
      tick_q   <= '0;
    end else if (start) begin
      active_q <= 1'b1;
      zero_q   <= (hold_ms == '0);
      ms_q     <= hold_ms;
      tick_q   <= '0;
    end else if (counting) begin
      if (expired) begin
        active_q <= 1'b0;
      end else if (tick_q == TickLast) begin
        tick_q <= '0;
        ms_q   <= ms_q - HOLD_W'(1);
      end else begin
        tick_q <= tick_q + TW'(1);
      end
    end
  end

endmodule

// File: rtl/vga_frame_sequencer.sv
// Streams ROM frames into the VGA line buffer and holds each for a programmable time.
module vga_frame_sequencer
  import vga_seq_pkg::*;
#(
  parameter int unsigned DATA_W      = 16,
  parameter int unsigned ROWS        = 16,
  parameter int unsigned FRAMES      = 6,
  parameter int unsigned TICK_CYCLES = 25000,
  parameter int unsigned HOLD_W      = 10,
  parameter int unsigned ROM_LAT     = 1,
  localparam int unsigned AW         = $clog2(FRAMES * ROWS),
  localparam int unsigned RW         = $clog2(ROWS),
  localparam int unsigned FW         = $clog2(FRAMES)
) (
  input  logic                  clk_vga,
  input  logic                  rst_n,
  input  logic                  run,
  input  logic [1:0]            mode,
  input  logic                  pause,
  input  logic [HOLD_W-1:0]     hold_ms,
  vga_frame_sequencer_if.master bus,
  output logic [FW-1:0]         frame_idx,
  output logic                  frame_strobe,
  output logic                  done
);

  localparam int unsigned DW = $clog2(ROM_LAT + 1);
  localparam logic [AW-1:0] RowsA     = AW'(ROWS);
  localparam logic [RW-1:0] RowLast   = RW'(ROWS - 1);
  localparam logic [FW-1:0] FrameLast = FW'(FRAMES - 1);
  localparam logic [DW-1:0] DrainLast = DW'(ROM_LAT - 1);

  seq_state_e state_q, state_d;
  logic [RW-1:0] row_q, row_d;
  logic [DW-1:0] drain_q, drain_d;
  logic [FW-1:0] frame_q, frame_d, next_frame;
  logic          dir_down_q, dir_down_d, next_dir_down;
  logic [AW-1:0] rom_addr_q, rom_addr_d;
  logic          strobe_q, done_q;
  logic          hold_start, hold_expired;

  logic [ROM_LAT-1:0]         vld_q;
  logic [ROM_LAT-1:0][RW-1:0] idx_q;

  ms_hold_timer #(
    .TICK_CYCLES (TICK_CYCLES),
    .HOLD_W      (HOLD_W)
  ) u_hold_timer (
    .clk_vga (clk_vga),
    .rst_n   (rst_n),
    .start   (hold_start),
    .hold_ms (hold_ms),
    .pause   (pause),
    .expired (hold_expired)
  );

  // Frame that follows the current one for the selected ordering.
  always_comb begin
    next_frame    = frame_q;
    next_dir_down = dir_down_q;
    case (mode)
      MODE_PINGPONG: begin
        if (!dir_down_q) begin
          if (frame_q == FrameLast) begin
            next_dir_down = 1'b1;
            next_frame    = frame_q - FW'(1);
          end else begin
            next_frame = frame_q + FW'(1);
          end
        end else if (frame_q == '0) begin
          next_dir_down = 1'b0;
          next_frame    = frame_q + FW'(1);
        end else begin
          next_frame = frame_q - FW'(1);
        end
      end
      MODE_LOOP, MODE_ONESHOT, 2'd3: begin
        next_frame = (frame_q == FrameLast) ? '0 : frame_q + FW'(1);
      end
    endcase
  end

  always_comb begin
    state_d    = state_q;
    row_d      = row_q;
    drain_d    = drain_q;
    frame_d    = frame_q;
    dir_down_d = dir_down_q;
    rom_addr_d = rom_addr_q;
    hold_start = 1'b0;
    case (state_q)
      StIdle: begin
        frame_d    = '0;
        dir_down_d = 1'b0;
        if (run) begin
          state_d    = StLoad;
          row_d      = '0;
          rom_addr_d = '0;
        end
      end
      StLoad: begin
        if (row_q == RowLast) begin
          state_d = StDrain;
          drain_d = '0;
        end else begin
          row_d      = row_q + RW'(1);
          rom_addr_d = rom_addr_q + AW'(1);
        end
      end
      StDrain: begin
        if (drain_q == DrainLast) begin
          state_d    = StHold;
          hold_start = 1'b1;
        end else begin
          drain_d = drain_q + DW'(1);
        end
      end
      StHold: begin
        if (hold_expired) begin
          if (!run) begin
            state_d    = StIdle;
            frame_d    = '0;
            dir_down_d = 1'b0;
          end else if (mode == MODE_ONESHOT && frame_q == FrameLast) begin
            state_d = StDone;
          end else begin
            state_d    = StLoad;
            frame_d    = next_frame;
            dir_down_d = next_dir_down;
            row_d      = '0;
            rom_addr_d = AW'(next_frame) * RowsA;
          end
        end
      end
      StDone: begin
        if (!run) begin
          state_d    = StIdle;
          frame_d    = '0;
          dir_down_d = 1'b0;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_vga or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StIdle;
      row_q      <= '0;
      drain_q    <= '0;
      frame_q    <= '0;
      dir_down_q <= 1'b0;
      rom_addr_q <= '0;
      strobe_q   <= 1'b0;
      done_q     <= 1'b0;
      vld_q      <= '0;
      idx_q      <= '0;
    end else begin
      state_q    <= state_d;
      row_q      <= row_d;
      drain_q    <= drain_d;
      frame_q    <= frame_d;
      dir_down_q <= dir_down_d;
      rom_addr_q <= rom_addr_d;
      strobe_q   <= hold_start;
      done_q     <= (state_d == StDone);
      // Row valid/index track the ROM pipeline so writes line up with rom_data.
      vld_q[0]   <= (state_q == StLoad);
      idx_q[0]   <= row_q;
      for (int i = 1; i < ROM_LAT; i++) begin
        vld_q[i] <= vld_q[i-1];
        idx_q[i] <= idx_q[i-1];
      end
    end
  end

  assign bus.rom_addr = rom_addr_q;
  assign bus.wr_en    = vld_q[ROM_LAT-1];
  assign bus.wr_addr  = idx_q[ROM_LAT-1];
  assign bus.wr_data  = bus.rom_data & {DATA_W{bus.wr_en}};
  assign frame_idx    = frame_q;
  assign frame_strobe = strobe_q;
  assign done         = done_q;

endmodule

// File: tb/tb_vga_frame_sequencer.sv
// Directed bench for vga_frame_sequencer with a 2-cycle behavioural ROM (data = addr).
module tb_vga_frame_sequencer;

  localparam int unsigned DATA_W = 16;
  localparam int unsigned ROWS   = 4;
  localparam int unsigned FRAMES = 3;
  localparam int unsigned TICKS  = 4;
  localparam int unsigned HOLD_W = 10;
  localparam int unsigned LAT    = 2;
  localparam int unsigned AW     = 4;
  localparam int unsigned RW     = 2;
  localparam int unsigned FW     = 2;

  logic              clk_vga;
  logic              rst_n;
  logic              run;
  logic [1:0]        mode;
  logic              pause;
  logic [HOLD_W-1:0] hold_ms;
  logic [FW-1:0]     frame_idx;
  logic              frame_strobe;
  logic              done;
  logic [AW-1:0]     rom_p1, rom_p2;

  int n_checks = 0;
  int n_errors = 0;

  vga_frame_sequencer_if #(.DATA_W(DATA_W), .AW(AW), .RW(RW)) bus ();

  vga_frame_sequencer #(
    .DATA_W      (DATA_W),
    .ROWS        (ROWS),
    .FRAMES      (FRAMES),
    .TICK_CYCLES (TICKS),
    .HOLD_W      (HOLD_W),
    .ROM_LAT     (LAT)
  ) dut (
    .clk_vga      (clk_vga),
    .rst_n        (rst_n),
    .run          (run),
    .mode         (mode),
    .pause        (pause),
    .hold_ms      (hold_ms),
    .bus          (bus),
    .frame_idx    (frame_idx),
    .frame_strobe (frame_strobe),
    .done         (done)
  );

  initial clk_vga = 1'b0;
  always #5 clk_vga = ~clk_vga;

  always_ff @(posedge clk_vga) begin
    rom_p1 <= bus.rom_addr;
    rom_p2 <= rom_p1;
  end
  assign bus.rom_data = DATA_W'(rom_p2);

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got %0h exp %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk_vga);
    #1;
  endtask

  // Entered at the first LOAD cycle of frame f; returns at the cycle after HOLD.
  // Pause is high for frame-relative cycles [p0, p0+plen).
  task automatic run_frame(input int f, input int hold, input int p0, input int plen);
    for (int k = 0; k < int'(ROWS + LAT) + hold; k++) begin
      if (k < int'(ROWS)) check_eq("rom_addr", 32'(bus.rom_addr), f * ROWS + k);
      check_eq("wr_en", 32'(bus.wr_en), 32'(k >= int'(LAT) && k < int'(ROWS + LAT)));
      if (k >= int'(LAT) && k < int'(ROWS + LAT)) begin
        check_eq("wr_addr", 32'(bus.wr_addr), k - LAT);
        check_eq("wr_data", 32'(bus.wr_data), f * ROWS + k - LAT);
      end
      check_eq("frame_strobe", 32'(frame_strobe), 32'(k == int'(ROWS + LAT)));
      check_eq("frame_idx", 32'(frame_idx), f);
      pause = (k + 1 >= p0) && (k + 1 < p0 + plen);
      tick();
    end
    pause = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1);
  end

  initial begin
    rst_n   = 1'b1;
    run     = 1'b0;
    mode    = 2'd0;
    pause   = 1'b0;
    hold_ms = '0;
    #2 rst_n = 1'b0;
    repeat (2) tick();
    check_eq("rst_rom_addr", 32'(bus.rom_addr), 0);
    check_eq("rst_wr_en", 32'(bus.wr_en), 0);
    check_eq("rst_wr_addr", 32'(bus.wr_addr), 0);
    check_eq("rst_wr_data", 32'(bus.wr_data), 0);
    check_eq("rst_frame_idx", 32'(frame_idx), 0);
    check_eq("rst_strobe", 32'(frame_strobe), 0);
    check_eq("rst_done", 32'(done), 0);
    rst_n = 1'b1;

    // Loop, 2 ms holds; pause in LOAD is harmless, 10 paused HOLD cycles stretch 8 -> 18.
    mode    = 2'd0;
    hold_ms = 10'd2;
    run     = 1'b1;
    tick();
    run_frame(0, 8, 0, 0);
    run_frame(1, 8, 1, 3);
    run_frame(2, 18, 8, 10);
    run_frame(0, 8, 0, 0);

    // run dropped mid-frame: frame completes, 1-cycle HOLD, then IDLE.
    run     = 1'b0;
    hold_ms = '0;
    run_frame(1, 1, 0, 0);
    check_eq("idle_frame_idx", 32'(frame_idx), 0);
    repeat (3) tick();
    check_eq("idle_wr_en", 32'(bus.wr_en), 0);
    check_eq("idle_strobe", 32'(frame_strobe), 0);

    // Ping-pong: 0,1,2,1,0,1,2 with zero-length holds.
    mode = 2'd2;
    run  = 1'b1;
    tick();
    run_frame(0, 1, 0, 0);
    run_frame(1, 1, 0, 0);
    run_frame(2, 1, 0, 0);
    run_frame(1, 1, 0, 0);
    run_frame(0, 1, 0, 0);
    run_frame(1, 1, 0, 0);
    run = 1'b0;
    run_frame(2, 1, 0, 0);
    check_eq("pp_idle_frame_idx", 32'(frame_idx), 0);

    // One-shot, 1 ms holds.
    mode    = 2'd1;
    hold_ms = 10'd1;
    run     = 1'b1;
    tick();
    run_frame(0, 4, 0, 0);
    run_frame(1, 4, 0, 0);
    run_frame(2, 4, 0, 0);
    check_eq("os_done", 32'(done), 1);
    check_eq("os_frame_idx", 32'(frame_idx), 2);
    repeat (3) tick();
    check_eq("os_done_hold", 32'(done), 1);
    check_eq("os_addr_stable", 32'(bus.rom_addr), 11);
    check_eq("os_no_write", 32'(bus.wr_en), 0);
    run = 1'b0;
    tick();
    check_eq("os_idle_done", 32'(done), 0);
    check_eq("os_idle_frame", 32'(frame_idx), 0);
    run = 1'b1;
    tick();
    run_frame(0, 4, 0, 0);

    // Asynchronous reset during frame 1 DRAIN.
    repeat (4) tick();
    check_eq("pre_rst_wr_en", 32'(bus.wr_en), 1);
    check_eq("pre_rst_frame", 32'(frame_idx), 1);
    rst_n = 1'b0;
    #1;
    check_eq("arst_wr_en", 32'(bus.wr_en), 0);
    check_eq("arst_rom_addr", 32'(bus.rom_addr), 0);
    check_eq("arst_frame_idx", 32'(frame_idx), 0);
    check_eq("arst_done", 32'(done), 0);
    check_eq("arst_wr_data", 32'(bus.wr_data), 0);
    repeat (2) tick();
    rst_n = 1'b1;
    tick();
    run_frame(0, 4, 0, 0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
